// File: rtl/afu_mem_responder.sv
// rtl/afu_mem_responder.sv - AFU cache-line memory responder with per-type request FIFOs
module afu_mem_responder #(
    parameter int ADDR_LMT        = 20,
    parameter int MDATA           = 14,
    parameter int CACHE_WIDTH     = 512,
    parameter int MEM_DEPTH_LOG2  = 6,
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int AF_THRESH       = 6,
    parameter int RD_LAT          = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [ADDR_LMT-1:0]    rd_req_addr,
    input  logic [MDATA-1:0]       rd_req_mdata,
    input  logic                   rd_req_en,
    output logic                   rd_req_almostfull,
    output logic                   rd_rsp_valid,
    output logic [MDATA-1:0]       rd_rsp_mdata,
    output logic [CACHE_WIDTH-1:0] rd_rsp_data,
    input  logic [ADDR_LMT-1:0]    wr_req_addr,
    input  logic [MDATA-1:0]       wr_req_mdata,
    input  logic [CACHE_WIDTH-1:0] wr_req_data,
    input  logic                   wr_req_en,
    output logic                   wr_req_almostfull,
    output logic                   wr_rsp0_valid,
    output logic [MDATA-1:0]       wr_rsp0_mdata,
    output logic                   wr_rsp1_valid,
    output logic [MDATA-1:0]       wr_rsp1_mdata,
    output logic                   err_overflow
);
    localparam int MW    = MEM_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2;
    localparam int CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_THRESH);

    // Only the memory-index bits of an address matter, so only those are queued.
    logic [MW-1:0]          rd_fifo_addr  [DEPTH];
    logic [MDATA-1:0]       rd_fifo_mdata [DEPTH];
    logic [MW-1:0]          wr_fifo_addr  [DEPTH];
    logic [MDATA-1:0]       wr_fifo_mdata [DEPTH];
    logic [CACHE_WIDTH-1:0] wr_fifo_data  [DEPTH];
    logic [CACHE_WIDTH-1:0] mem           [1 << MW];

    logic [PW-1:0]          rd_wptr, rd_rptr, wr_wptr, wr_rptr;
    logic [CW-1:0]          rd_cnt, wr_cnt, rd_cnt_next, wr_cnt_next;
    logic                   pri_wr, srv_rd, srv_wr;
    logic                   rd_push, wr_push, rd_drop, wr_drop;
    logic [RD_LAT-1:0]      pipe_valid;
    logic [MDATA-1:0]       pipe_mdata [RD_LAT];
    logic [CACHE_WIDTH-1:0] pipe_data  [RD_LAT];
    logic                   wr_done_valid, wr_ch;
    logic [MDATA-1:0]       wr_done_mdata;
    logic                   unused_addr_bits;

    assign unused_addr_bits = &{1'b0, rd_req_addr[ADDR_LMT-1:MW], wr_req_addr[ADDR_LMT-1:MW]};

    always_comb begin
        srv_rd  = (rd_cnt != '0) && ((wr_cnt == '0) || !pri_wr);
        srv_wr  = (wr_cnt != '0) && !srv_rd;
        rd_push = rd_req_en && ((rd_cnt != FULL_CNT) || srv_rd);
        wr_push = wr_req_en && ((wr_cnt != FULL_CNT) || srv_wr);
        rd_drop = rd_req_en && !rd_push;
        wr_drop = wr_req_en && !wr_push;
        rd_cnt_next = rd_cnt;
        if (rd_push && !srv_rd)
            rd_cnt_next = rd_cnt + CW'(1);
        else if (!rd_push && srv_rd)
            rd_cnt_next = rd_cnt - CW'(1);
        wr_cnt_next = wr_cnt;
        if (wr_push && !srv_wr)
            wr_cnt_next = wr_cnt + CW'(1);
        else if (!wr_push && srv_wr)
            wr_cnt_next = wr_cnt - CW'(1);
    end

    // Datapath storage carries no reset; validity lives in the control block below.
    always_ff @(posedge clk) begin
        if (rd_push) begin
            rd_fifo_addr[rd_wptr]  <= rd_req_addr[MW-1:0];
            rd_fifo_mdata[rd_wptr] <= rd_req_mdata;
        end
        if (wr_push) begin
            wr_fifo_addr[wr_wptr]  <= wr_req_addr[MW-1:0];
            wr_fifo_mdata[wr_wptr] <= wr_req_mdata;
            wr_fifo_data[wr_wptr]  <= wr_req_data;
        end
        if (srv_wr)
            mem[wr_fifo_addr[wr_rptr]] <= wr_fifo_data[wr_rptr];
        if (srv_rd) begin
            pipe_mdata[0] <= rd_fifo_mdata[rd_rptr];
            pipe_data[0]  <= mem[rd_fifo_addr[rd_rptr]];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_mdata[i] <= pipe_mdata[i-1];
            pipe_data[i]  <= pipe_data[i-1];
        end
        if (srv_wr)
            wr_done_mdata <= wr_fifo_mdata[wr_rptr];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_wptr           <= '0;
            rd_rptr           <= '0;
            wr_wptr           <= '0;
            wr_rptr           <= '0;
            rd_cnt            <= '0;
            wr_cnt            <= '0;
            rd_req_almostfull <= 1'b0;
            wr_req_almostfull <= 1'b0;
            err_overflow      <= 1'b0;
            pri_wr            <= 1'b0;
            pipe_valid        <= '0;
            rd_rsp_valid      <= 1'b0;
            rd_rsp_mdata      <= '0;
            rd_rsp_data       <= '0;
            wr_done_valid     <= 1'b0;
            wr_ch             <= 1'b0;
            wr_rsp0_valid     <= 1'b0;
            wr_rsp0_mdata     <= '0;
            wr_rsp1_valid     <= 1'b0;
            wr_rsp1_mdata     <= '0;
        end else begin
            if (rd_push) rd_wptr <= rd_wptr + PW'(1);
            if (srv_rd)  rd_rptr <= rd_rptr + PW'(1);
            if (wr_push) wr_wptr <= wr_wptr + PW'(1);
            if (srv_wr)  wr_rptr <= wr_rptr + PW'(1);
            rd_cnt            <= rd_cnt_next;
            wr_cnt            <= wr_cnt_next;
            rd_req_almostfull <= rd_cnt_next >= AF_CNT;
            wr_req_almostfull <= wr_cnt_next >= AF_CNT;
            err_overflow      <= err_overflow | rd_drop | wr_drop;
            if (srv_rd)
                pri_wr <= 1'b1;
            else if (srv_wr)
                pri_wr <= 1'b0;
            pipe_valid[0] <= srv_rd;
            for (int i = 1; i < RD_LAT; i++)
                pipe_valid[i] <= pipe_valid[i-1];
            rd_rsp_valid <= pipe_valid[RD_LAT-1];
            if (pipe_valid[RD_LAT-1]) begin
                rd_rsp_mdata <= pipe_mdata[RD_LAT-1];
                rd_rsp_data  <= pipe_data[RD_LAT-1];
            end
            wr_done_valid <= srv_wr;
            wr_rsp0_valid <= wr_done_valid && !wr_ch;
            wr_rsp1_valid <= wr_done_valid && wr_ch;
            if (wr_done_valid) begin
                wr_ch <= ~wr_ch;
                if (wr_ch)
                    wr_rsp1_mdata <= wr_done_mdata;
                else
                    wr_rsp0_mdata <= wr_done_mdata;
            end
        end
    end
endmodule

// File: tb/tb_afu_mem_responder.sv
// tb/tb_afu_mem_responder.sv - scoreboard bench for afu_mem_responder
module tb_afu_mem_responder;
    localparam int ADDR_LMT    = 20;
    localparam int MDATA       = 14;
    localparam int CACHE_WIDTH = 512;
    localparam int RD_LAT      = 2;
    localparam int AF_THRESH   = 6;
    localparam int DEPTH       = 8;

    logic                   clk, reset_n;
    logic [ADDR_LMT-1:0]    rd_req_addr, wr_req_addr;
    logic [MDATA-1:0]       rd_req_mdata, wr_req_mdata;
    logic [CACHE_WIDTH-1:0] wr_req_data;
    logic                   rd_req_en, wr_req_en;
    logic                   rd_req_almostfull, wr_req_almostfull;
    logic                   rd_rsp_valid, wr_rsp0_valid, wr_rsp1_valid, err_overflow;
    logic [MDATA-1:0]       rd_rsp_mdata, wr_rsp0_mdata, wr_rsp1_mdata;
    logic [CACHE_WIDTH-1:0] rd_rsp_data;

    afu_mem_responder dut (
        .clk(clk), .reset_n(reset_n),
        .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata), .rd_req_en(rd_req_en),
        .rd_req_almostfull(rd_req_almostfull), .rd_rsp_valid(rd_rsp_valid),
        .rd_rsp_mdata(rd_rsp_mdata), .rd_rsp_data(rd_rsp_data),
        .wr_req_addr(wr_req_addr), .wr_req_mdata(wr_req_mdata), .wr_req_data(wr_req_data),
        .wr_req_en(wr_req_en), .wr_req_almostfull(wr_req_almostfull),
        .wr_rsp0_valid(wr_rsp0_valid), .wr_rsp0_mdata(wr_rsp0_mdata),
        .wr_rsp1_valid(wr_rsp1_valid), .wr_rsp1_mdata(wr_rsp1_mdata),
        .err_overflow(err_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [MDATA-1:0]       mdata;
        logic [CACHE_WIDTH-1:0] data;
        bit                     chk_data;
        int                     exp_cyc;
    } rsp_t;

    rsp_t rd_q[$];
    rsp_t wr_q[$];

    int vectors, miscompares, cyc;
    int m_rc, m_wc;
    bit m_pri_wr, m_ovf, m_ch;
    logic [CACHE_WIDTH-1:0] m_mem [64];
    bit m_known [64];
    bit saw_af_r, saw_af_w;

    task automatic check(input string tag, input logic [CACHE_WIDTH-1:0] obs, input logic [CACHE_WIDTH-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        rsp_t e;
        bit   ch;
        if (rd_rsp_valid) begin
            if (rd_q.size() == 0) begin
                check("rd_rsp_spurious", rd_rsp_valid, 1'b0);
            end else begin
                e = rd_q.pop_front();
                check("rd_mdata", rd_rsp_mdata, e.mdata);
                if (e.chk_data) check("rd_data", rd_rsp_data, e.data);
                if (e.exp_cyc >= 0) check("rd_latency", cyc, e.exp_cyc);
            end
        end
        check("wr_single_channel", wr_rsp0_valid & wr_rsp1_valid, 1'b0);
        if (wr_rsp0_valid ^ wr_rsp1_valid) begin
            ch = wr_rsp1_valid;
            if (wr_q.size() == 0) begin
                check("wr_rsp_spurious", 1'b1 & (wr_rsp0_valid | wr_rsp1_valid), 1'b0);
            end else begin
                e = wr_q.pop_front();
                check("wr_channel", ch, m_ch);
                m_ch = ~m_ch;
                check("wr_mdata", ch ? wr_rsp1_mdata : wr_rsp0_mdata, e.mdata);
                if (e.exp_cyc >= 0) check("wr_latency", cyc, e.exp_cyc);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        rd_req_en = 1'b0;
        wr_req_en = 1'b0;
        rd_q.delete();
        wr_q.delete();
        m_rc = 0; m_wc = 0; m_pri_wr = 1'b0; m_ovf = 1'b0; m_ch = 1'b0;
        tick();
        check("rst_rd_valid", rd_rsp_valid, 1'b0);
        check("rst_wr0_valid", wr_rsp0_valid, 1'b0);
        check("rst_wr1_valid", wr_rsp1_valid, 1'b0);
        check("rst_rd_mdata", rd_rsp_mdata, '0);
        check("rst_rd_data", rd_rsp_data, '0);
        check("rst_wr0_mdata", wr_rsp0_mdata, '0);
        check("rst_wr1_mdata", wr_rsp1_mdata, '0);
        check("rst_rd_af", rd_req_almostfull, 1'b0);
        check("rst_wr_af", wr_req_almostfull, 1'b0);
        check("rst_overflow", err_overflow, 1'b0);
        reset_n = 1'b1;
    endtask

    task automatic do_cycle(input bit re, input logic [ADDR_LMT-1:0] ra, input logic [MDATA-1:0] rm,
                            input bit we, input logic [ADDR_LMT-1:0] wa, input logic [MDATA-1:0] wm,
                            input logic [CACHE_WIDTH-1:0] wd);
        rsp_t e;
        bit   srv_rd, srv_wr, acc_r, acc_w;
        rd_req_en = re; rd_req_addr = ra; rd_req_mdata = rm;
        wr_req_en = we; wr_req_addr = wa; wr_req_mdata = wm; wr_req_data = wd;
        srv_rd = (m_rc > 0) && ((m_wc == 0) || !m_pri_wr);
        srv_wr = (m_wc > 0) && !srv_rd;
        acc_r  = re && ((m_rc < DEPTH) || srv_rd);
        acc_w  = we && ((m_wc < DEPTH) || srv_wr);
        if ((re && !acc_r) || (we && !acc_w)) m_ovf = 1'b1;
        if (acc_r) begin
            e.mdata    = rm;
            e.data     = m_mem[ra[5:0]];
            e.chk_data = m_known[ra[5:0]];
            e.exp_cyc  = (m_rc == 0 && m_wc == 0 && !we) ? cyc + 2 + RD_LAT : -1;
            rd_q.push_back(e);
        end
        if (acc_w) begin
            e.mdata    = wm;
            e.data     = wd;
            e.chk_data = 1'b0;
            e.exp_cyc  = (m_rc == 0 && m_wc == 0 && !re) ? cyc + 3 : -1;
            wr_q.push_back(e);
            m_mem[wa[5:0]]   = wd;
            m_known[wa[5:0]] = 1'b1;
        end
        m_rc = m_rc + int'(acc_r) - int'(srv_rd);
        m_wc = m_wc + int'(acc_w) - int'(srv_wr);
        if (srv_rd) m_pri_wr = 1'b1;
        else if (srv_wr) m_pri_wr = 1'b0;
        tick();
        rd_req_en = 1'b0;
        wr_req_en = 1'b0;
        check("rd_almostfull", rd_req_almostfull, m_rc >= AF_THRESH);
        check("wr_almostfull", wr_req_almostfull, m_wc >= AF_THRESH);
        check("err_overflow", err_overflow, m_ovf);
    endtask

    task automatic idle(input int n);
        repeat (n) do_cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && (rd_q.size() != 0 || wr_q.size() != 0); i++)
            idle(1);
        check("drain_pending", rd_q.size() + wr_q.size(), 0);
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        reset_n = 1'b0;
        rd_req_en = 1'b0; rd_req_addr = '0; rd_req_mdata = '0;
        wr_req_en = 1'b0; wr_req_addr = '0; wr_req_mdata = '0; wr_req_data = '0;
        for (int i = 0; i < 64; i++) m_known[i] = 1'b0;
        apply_reset();

        // Write then read back one line with uncontended latency checks.
        do_cycle(1'b0, '0, '0, 1'b1, 20'd5, 14'd3, {64{8'hA5}});
        idle(3);
        do_cycle(1'b1, 20'd5, 14'd7, 1'b0, '0, '0, '0);
        drain();

        // Back-to-back writes alternate completion channels from channel 0.
        apply_reset();
        for (int i = 1; i <= 4; i++)
            do_cycle(1'b0, '0, '0, 1'b1, ADDR_LMT'(19 + i), MDATA'(i), {16{i}});
        drain();

        // Line 0x40 aliases line 0x00.
        do_cycle(1'b0, '0, '0, 1'b1, 20'h40, 14'd10, {64{8'h11}});
        idle(2);
        do_cycle(1'b1, 20'h00, 14'd11, 1'b0, '0, '0, '0);
        drain();

        // Same-cycle read and write of line 9 with read priority: read sees old data.
        do_cycle(1'b0, '0, '0, 1'b1, 20'd9, 14'd20, {16{32'hD0D0_0000}});
        drain();
        apply_reset();
        do_cycle(1'b1, 20'd9, 14'd21, 1'b1, 20'd9, 14'd22, {16{32'hD1D1_1111}});
        drain();
        do_cycle(1'b1, 20'd9, 14'd23, 1'b0, '0, '0, '0);
        drain();

        // Saturate both FIFOs.
        saw_af_r = 1'b0;
        saw_af_w = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_cycle(1'b1, ADDR_LMT'(i), MDATA'(100 + i), 1'b1, ADDR_LMT'(32 + i), MDATA'(200 + i), {16{i}});
            saw_af_r |= rd_req_almostfull;
            saw_af_w |= wr_req_almostfull;
        end
        check("stress_rd_af_rose", saw_af_r, 1'b1);
        check("stress_wr_af_rose", saw_af_w, 1'b1);
        check("stress_overflow_set", err_overflow, 1'b1);
        drain();

        // Reset with reads in flight discards them and clears the sticky flag.
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, 20'd5, MDATA'(30 + i), 1'b0, '0, '0, '0);
        apply_reset();
        idle(8);
        check("post_reset_rd_queue", rd_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
